// File: rtl/tia_audio_mixer.sv
// tia_audio_mixer: mixes the two TIA audio channel bits by volume, box-filter
// decimates the mixed level over DECIM enabled clocks, and hands the PCM
// samples to the sound path through a 2-entry valid/ready buffer.
// Optional feature macro: TIA_PWM_OUT_EN adds a 1-bit PWM rendering of the
// instantaneous mixed level on pwm_out.
module tia_audio_mixer #(
    parameter int DECIM = 64,
    localparam int SUM_W = 5 + $clog2(DECIM),
    localparam int CNT_W = $clog2(DECIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ch0_bit,
    input  logic [3:0]       ch0_vol,
    input  logic             ch1_bit,
    input  logic [3:0]       ch1_vol,
    output logic [SUM_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    input  logic             overrun_clr
`ifdef TIA_PWM_OUT_EN
    ,
    output logic             pwm_out
`endif
);

    logic [4:0]       w_level;
    logic [SUM_W-1:0] w_sum;
    logic             w_push;
    logic             w_pop;

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] r_tail;
    logic [1:0]       r_count;

    // Instantaneous mix level, completed window sum, and buffer handshakes.
    always_comb begin
        w_level = (ch0_bit ? {1'b0, ch0_vol} : 5'd0) + (ch1_bit ? {1'b0, ch1_vol} : 5'd0);
        w_sum   = r_acc + SUM_W'(w_level);
        w_push  = en && (r_cnt == CNT_W'(DECIM - 1));
        w_pop   = sample_valid && sample_ready;
    end

    // Decimation window: accumulate while enabled, restart after the last clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (en) begin
            if (w_push) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_acc <= w_sum;
            end
        end else begin
            r_cnt <= r_cnt;
            r_acc <= r_acc;
        end
    end

    // Two-entry in-order buffer; sample_data is the registered head, 0 when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_data  <= '0;
            r_tail       <= '0;
            r_count      <= 2'd0;
            sample_valid <= 1'b0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        sample_data  <= w_sum;
                        r_count      <= 2'd1;
                        sample_valid <= 1'b1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        sample_data <= w_sum;
                    end else if (w_push) begin
                        r_tail  <= w_sum;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        sample_data  <= '0;
                        r_count      <= 2'd0;
                        sample_valid <= 1'b0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        sample_data <= r_tail;
                        if (w_push) begin
                            r_tail <= w_sum;
                        end else begin
                            r_tail  <= '0;
                            r_count <= 2'd1;
                        end
                    end
                end
                default: begin
                    sample_data  <= '0;
                    r_tail       <= '0;
                    r_count      <= 2'd0;
                    sample_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: a drop (full, no pop) wins over a same-edge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (w_push && (r_count == 2'd2) && !w_pop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun;
        end
    end

`ifdef TIA_PWM_OUT_EN
    logic [4:0] r_pwm_cnt;
    logic [4:0] r_level_q;

    // Free-running 30-clock PWM frame; level is captured at each frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= 5'd0;
            r_level_q <= 5'd0;
            pwm_out   <= 1'b0;
        end else begin
            if (r_pwm_cnt == 5'd29) begin
                r_pwm_cnt <= 5'd0;
                r_level_q <= w_level;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + 5'd1;
            end
            pwm_out <= (r_pwm_cnt < r_level_q);
        end
    end
`endif

endmodule
